full_adder_exerciser: RTL and testbench

Self-checking stimulus generator for the 1-bit full-adder board test: drives the adder's three PMOD inputs (a, b, carry-in) through all 8 combinations and reads back the adder's sum and carry outputs. Compares each response against the golden full-adder result and reports progress, pass and fail on the iCEstick LEDs. Sits on the other end of the PMOD wiring, or on the same die wired to the adder instance.

---
 rtl/full_adder_exerciser_if.sv | 25 ++
 rtl/full_adder_exerciser.sv | 158 +++++++++++++++
 tb/tb_full_adder_exerciser.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_exerciser_if.sv
// PMOD-side signal bundle between the full-adder exerciser and the adder under test.
// master = exerciser side, slave = adder/board side.
interface full_adder_exerciser_if;
    logic       start;
    logic       sum_in;
    logic       carry_in;
    logic [2:0] pmod_out;
    logic [4:0] led;

    modport master (
        input  start,
        input  sum_in,
        input  carry_in,
        output pmod_out,
        output led
    );

    modport slave (
        output start,
        output sum_in,
        output carry_in,
        input  pmod_out,
        input  led
    );
endinterface

// File: rtl/full_adder_exerciser.sv
// Walks a 1-bit full adder through all 8 input vectors, checks sum/carry against the
// golden result and shows progress, pass and fail on the LEDs.
module full_adder_exerciser #(
    parameter int TICK_DIV = 12_000_000,
    parameter int SETTLE   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    full_adder_exerciser_if.master        bus,
    output logic [2:0]                    dbg_state_o
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int SET_W  = $clog2(SETTLE + 1);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);

    // Encoding is part of the debug contract on dbg_state_o.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_HOLD   = 3'd4,
        S_PASS   = 3'd5,
        S_FAIL   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          vec_q, vec_d;
    logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]          pmod_q, pmod_d;
    logic [4:0]          led_q, led_d;
    logic                start_q;
    logic                sum_s1_q, sum_s2_q;
    logic                carry_s1_q, carry_s2_q;

    logic                start_rise;
    logic [1:0]          resp;
    logic [1:0]          expected;

    assign start_rise = bus.start & ~start_q;
    assign resp       = {carry_s2_q, sum_s2_q};
    assign expected   = {(vec_q[0] & vec_q[1]) | (vec_q[0] & vec_q[2]) | (vec_q[1] & vec_q[2]),
                         vec_q[0] ^ vec_q[1] ^ vec_q[2]};

    // Edge detector and synchronizers run in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            sum_s1_q   <= 1'b0;
            sum_s2_q   <= 1'b0;
            carry_s1_q <= 1'b0;
            carry_s2_q <= 1'b0;
        end else begin
            start_q    <= bus.start;
            sum_s1_q   <= bus.sum_in;
            sum_s2_q   <= sum_s1_q;
            carry_s1_q <= bus.carry_in;
            carry_s2_q <= carry_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= 3'd0;
            settle_cnt_q <= '0;
            tick_cnt_q   <= '0;
            pmod_q       <= 3'd0;
            led_q        <= 5'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            pmod_q       <= pmod_d;
            led_q        <= led_d;
        end
    end

    // Counters fall back to 0 outside their own state, so each starts at 0 on entry.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_cnt_d = '0;
        tick_cnt_d   = '0;
        pmod_d       = pmod_q;
        led_d        = led_q;

        case (state_q)
            S_IDLE: begin
                pmod_d = 3'd0;
                led_d  = 5'd0;
                if (start_rise) begin
                    vec_d   = 3'd0;
                    state_d = S_DRIVE;
                end
            end

            S_DRIVE: begin
                pmod_d  = vec_q;
                led_d   = {1'b0, 1'b1, vec_q};
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end

            S_CHECK: begin
                if (resp != expected) begin
                    state_d = S_FAIL;
                    led_d   = {1'b1, 1'b0, vec_q};
                end else if (vec_q == 3'd7) begin
                    state_d = S_PASS;
                end else begin
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (tick_cnt_q == TICK_LAST) begin
                    vec_d   = vec_q + 3'd1;
                    state_d = S_DRIVE;
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                end
            end

            S_PASS, S_FAIL: begin
                // Restart clears the fail LED together with the move to DRIVE.
                if (start_rise) begin
                    vec_d   = 3'd0;
                    state_d = S_DRIVE;
                    led_d   = {1'b0, led_q[3:0]};
                end
            end

            default: begin
                state_d = S_IDLE;
                pmod_d  = 3'd0;
                led_d   = 5'd0;
            end
        endcase
    end

    assign bus.pmod_out = pmod_q;
    assign bus.led      = led_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_full_adder_exerciser.sv
// Bench for full_adder_exerciser: behavioural adder with selectable faults on the PMOD
// side, outcome and timing predicted from the full-adder truth table.
module tb_full_adder_exerciser;

  localparam int TICK_DIV = 8;
  localparam int SETTLE   = 4;
  localparam int PER      = 1 + SETTLE + 1 + TICK_DIV;

  localparam int ST_IDLE  = 0;
  localparam int ST_DRIVE = 1;
  localparam int ST_CHECK = 3;
  localparam int ST_HOLD  = 4;
  localparam int ST_PASS  = 5;
  localparam int ST_FAIL  = 6;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  full_adder_exerciser_if bus ();

  full_adder_exerciser #(
    .TICK_DIV (TICK_DIV),
    .SETTLE   (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural adder on the far side of the PMOD wiring, with optional fault
  int   mode;
  logic glitch;
  int   tot;
  logic ms, mc;

  always_comb begin
    tot = int'(bus.pmod_out[0]) + int'(bus.pmod_out[1]) + int'(bus.pmod_out[2]);
    ms  = (tot % 2) == 1;
    mc  = (tot / 2) == 1;
    case (mode)
      1: mc = 1'b0;
      2: ms = ~ms;
      3: mc = 1'b1;
      4: ms = 1'b0;
      5: ms = 1'b1;
      6: mc = ~mc;
      default: ;
    endcase
    bus.sum_in   = ms ^ glitch;
    bus.carry_in = mc;
  end

  // reference: first vector whose faulty response differs from a+b+c, -1 if none
  function automatic int first_fail(input int m);
    int total;
    int gs, gc, fs, fc;
    for (int v = 0; v < 8; v++) begin
      total = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
      gs = total % 2;
      gc = total / 2;
      fs = gs;
      fc = gc;
      case (m)
        1: fc = 0;
        2: fs = 1 - gs;
        3: fc = 1;
        4: fs = 0;
        5: fs = 1;
        6: fc = 1 - gc;
        default: ;
      endcase
      if (fs != gs || fc != gc) return v;
    end
    return -1;
  endfunction

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;
  int t_now = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // advance to the negedge that follows posedge number n of the current run
  task automatic at(input int n);
    if (n > t_now) cyc(n - t_now);
    t_now = n;
  endtask

  // one run; start stays high afterwards. fail_v = -1 expects PASS.
  task automatic run(input int fail_v, input int glitch_v, input int pulse_v);
    int  base;
    bit  done;
    logic [2:0] v3;
    bus.start = 1'b0;
    cyc($urandom_range(1, 4));
    bus.start = 1'b1;
    cyc(1);
    t_now = 0;
    done  = 1'b0;
    for (int v = 0; v < 8 && !done; v++) begin
      base = PER * v;
      v3   = 3'(v);
      at(base);
      chk($sformatf("drive_v%0d", v), 32'(dbg_state), ST_DRIVE);
      if (v == 0) chk("led4_clear_on_start", 32'(bus.led[4]), 0);
      at(base + 1);
      chk($sformatf("pmod_v%0d", v), 32'(bus.pmod_out), 32'(v3));
      chk($sformatf("led_v%0d", v), 32'(bus.led), 32'({2'b01, v3}));
      if (v == glitch_v) begin
        glitch = 1'b1;
        at(base + 2);
        glitch = 1'b0;
      end
      if (v == pulse_v) begin
        at(base + 2);
        bus.start = 1'b0;
        at(base + 3);
        bus.start = 1'b1;
      end
      if (v == fail_v) begin
        at(base + 2 + SETTLE);
        chk($sformatf("fail_state_v%0d", v), 32'(dbg_state), ST_FAIL);
        chk($sformatf("fail_led_v%0d", v), 32'(bus.led), 32'({2'b10, v3}));
        chk($sformatf("fail_pmod_v%0d", v), 32'(bus.pmod_out), 32'(v3));
        at(base + 2 + SETTLE + $urandom_range(3, 20));
        chk("fail_led_frozen", 32'(bus.led), 32'({2'b10, v3}));
        chk("fail_pmod_frozen", 32'(bus.pmod_out), 32'(v3));
        done = 1'b1;
      end else if (v == 7) begin
        at(base + 1 + SETTLE);
        chk("check_before_pass", 32'(dbg_state), ST_CHECK);
        at(base + 2 + SETTLE);
        chk("pass_cycle_count", 32'(t_now), 8 * (SETTLE + 2) + 7 * TICK_DIV);
        chk("pass_state", 32'(dbg_state), ST_PASS);
        chk("pass_led", 32'(bus.led), 32'(5'b01111));
        chk("pass_pmod", 32'(bus.pmod_out), 7);
      end else begin
        at(base + 1 + SETTLE + TICK_DIV);
        chk($sformatf("hold_v%0d", v), 32'(dbg_state), ST_HOLD);
        chk($sformatf("hold_pmod_v%0d", v), 32'(bus.pmod_out), 32'(v3));
      end
    end
  endtask

  initial begin
    int m;
    int pv;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    mode      = 0;
    glitch    = 1'b0;

    // reset state
    cyc(3);
    chk("reset_pmod", 32'(bus.pmod_out), 0);
    chk("reset_led", 32'(bus.led), 0);
    chk("reset_state", 32'(dbg_state), ST_IDLE);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_no_start", 32'(dbg_state), ST_IDLE);

    // good adder, sum glitch one cycle after DRIVE, start pulsed during SETTLE
    mode = 0;
    run(-1, $urandom_range(0, 7), $urandom_range(0, 7));
    cyc(12);
    chk("pass_start_held_high", 32'(dbg_state), ST_PASS);
    chk("pass_led_held", 32'(bus.led), 32'(5'b01111));

    // carry stuck at 0
    mode = 1;
    run(first_fail(1), -1, -1);

    // sum inverted, then restart with a good adder
    mode = 2;
    run(first_fail(2), -1, -1);
    mode = 0;
    run(-1, -1, -1);

    // randomized fault models
    for (int i = 0; i < 6; i++) begin
      m    = $urandom_range(0, 6);
      pv   = $urandom_range(0, 7);
      mode = m;
      run(first_fail(m), -1, pv);
    end

    // async reset while holding vector 5
    mode = 0;
    bus.start = 1'b0;
    cyc(2);
    bus.start = 1'b1;
    cyc(1);
    t_now = 0;
    at(PER * 5 + 1 + SETTLE + 3);
    chk("pre_reset_hold", 32'(dbg_state), ST_HOLD);
    chk("pre_reset_pmod", 32'(bus.pmod_out), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pmod", 32'(bus.pmod_out), 0);
    chk("async_reset_led", 32'(bus.led), 0);
    chk("async_reset_state", 32'(dbg_state), ST_IDLE);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(20);
    chk("post_reset_idle", 32'(dbg_state), ST_IDLE);
    chk("post_reset_led", 32'(bus.led), 0);
    chk("post_reset_pmod", 32'(bus.pmod_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
